// File: rtl/motor_rpm_plant.sv
// Motor/ESC plant model: per-channel first-order lag toward mot_set with slew limit and saturation.
// A preload input opens the loop, and a settle detector reports sustained in-band tracking.
module motor_rpm_plant #(
  parameter int NUM_MOT       = 4,
  parameter int W             = 16,
  parameter int SHIFT         = 2,
  parameter int MAX_STEP      = 1000,
  parameter int PRESCALE      = 1,
  parameter int TOL           = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        set,
  input  logic [NUM_MOT-1:0][W-1:0]   rpm_sense_set,
  input  logic [NUM_MOT-1:0][W-1:0]   mot_set,
  output logic [NUM_MOT-1:0][W-1:0]   rpm_sense,
  output logic                        settled
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [PW-1:0]       PLAST   = PW'(PRESCALE - 1);
  localparam logic [SW-1:0]       SMAX    = SW'(STABLE_CYCLES);
  localparam logic signed [W:0]   ZERO    = '0;
  localparam logic signed [W:0]   ONE     = (W+1)'(1);
  localparam logic signed [W:0]   STEP_HI = (W+1)'(MAX_STEP);
  localparam logic signed [W:0]   STEP_LO = -STEP_HI;
  localparam logic signed [W:0]   TOL_HI  = (W+1)'(TOL);
  localparam logic signed [W:0]   TOL_LO  = -TOL_HI;
  localparam logic signed [W:0]   SAT_HI  = (W+1)'((1 << (W-1)) - 1);
  localparam logic signed [W:0]   SAT_LO  = -SAT_HI - ONE;

  logic [PW-1:0]              pcnt;
  logic [SW-1:0]              scnt;
  logic [SW-1:0]              scnt_nxt;
  logic                       tick;
  logic                       all_in;
  logic [NUM_MOT-1:0]         in_band;
  logic signed [W:0]          err  [NUM_MOT];
  logic signed [W:0]          step [NUM_MOT];
  logic signed [W:0]          sum  [NUM_MOT];
  logic [NUM_MOT-1:0][W-1:0]  upd;

  // All arithmetic runs at W+1 bits so full-scale error and the saturating add never wrap.
  always_comb begin
    tick = (pcnt == PLAST);
    upd  = rpm_sense;
    for (int i = 0; i < NUM_MOT; i++) begin
      err[i]  = $signed({mot_set[i][W-1], mot_set[i]}) - $signed({rpm_sense[i][W-1], rpm_sense[i]});
      step[i] = err[i] >>> SHIFT;
      if (err[i] > ZERO && step[i] == ZERO) begin
        step[i] = ONE;
      end else if (err[i] < ZERO && step[i] == ZERO) begin
        step[i] = -ONE;
      end
      if (step[i] > STEP_HI) begin
        step[i] = STEP_HI;
      end else if (step[i] < STEP_LO) begin
        step[i] = STEP_LO;
      end
      sum[i] = $signed({rpm_sense[i][W-1], rpm_sense[i]}) + step[i];
      if (sum[i] > SAT_HI) begin
        upd[i] = SAT_HI[W-1:0];
      end else if (sum[i] < SAT_LO) begin
        upd[i] = SAT_LO[W-1:0];
      end else begin
        upd[i] = sum[i][W-1:0];
      end
      in_band[i] = (err[i] <= TOL_HI) && (err[i] >= TOL_LO);
    end
    all_in = &in_band;
    if (!all_in) begin
      scnt_nxt = '0;
    end else if (scnt == SMAX) begin
      scnt_nxt = scnt;
    end else begin
      scnt_nxt = scnt + 1'b1;
    end
  end

  // Preload has priority over update ticks and restarts both the prescaler and the settle count.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rpm_sense <= '0;
      pcnt      <= '0;
      scnt      <= '0;
      settled   <= 1'b0;
    end else if (set) begin
      rpm_sense <= rpm_sense_set;
      pcnt      <= '0;
      scnt      <= '0;
      settled   <= 1'b0;
    end else begin
      pcnt    <= tick ? '0 : pcnt + 1'b1;
      scnt    <= scnt_nxt;
      settled <= (scnt_nxt == SMAX);
      if (tick) begin
        rpm_sense <= upd;
      end
    end
  end

endmodule

// File: tb/tb_motor_rpm_plant.sv
// Scoreboard bench for motor_rpm_plant: stimulus queues hand-computed expectations by cycle,
// a monitor pops and compares them on the falling edge (or immediately for async-reset checks).
module tb_motor_rpm_plant;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             set = 1'b0;
  logic [3:0][15:0] rpmSenseSet = '0;
  logic [3:0][15:0] motSet = '0;
  logic [3:0][15:0] rpmSense;
  logic [3:0][15:0] rpmSense4;
  logic             settled;
  logic             settled4;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int    due;
    int    sel;
    int    ch;
    int    val;
    string name;
  } item_t;

  item_t sbq[$];
  event  immEv;

  motor_rpm_plant dut (
    .clk(clk), .resetn(resetn), .set(set), .rpm_sense_set(rpmSenseSet),
    .mot_set(motSet), .rpm_sense(rpmSense), .settled(settled)
  );

  motor_rpm_plant #(.PRESCALE(4)) dut4 (
    .clk(clk), .resetn(resetn), .set(set), .rpm_sense_set(rpmSenseSet),
    .mot_set(motSet), .rpm_sense(rpmSense4), .settled(settled4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0][15:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [3:0][15:0] r;
    r[0] = 16'(c0);
    r[1] = 16'(c1);
    r[2] = 16'(c2);
    r[3] = 16'(c3);
    return r;
  endfunction

  function automatic logic signed [31:0] actual(input int sel, input int ch);
    logic [1:0] c;
    c = ch[1:0];
    case (sel)
      0:       return 32'($signed(rpmSense[c]));
      1:       return {31'b0, settled};
      2:       return 32'($signed(rpmSense4[c]));
      default: return {31'b0, settled4};
    endcase
  endfunction

  task automatic checkOutput(input item_t it);
    logic signed [31:0] act;
    act = actual(it.sel, it.ch);
    checks++;
    if (act !== 32'(it.val)) begin
      failures++;
      $display("[TB] FAIL %s ch%0d: got %0d expected %0d (cycle %0d)", it.name, it.ch, act, it.val, cyc);
    end
  endtask

  task automatic expectAt(input int due, input int sel, input int ch, input int val, input string name);
    item_t it;
    int idx;
    it.due = due; it.sel = sel; it.ch = ch; it.val = val; it.name = name;
    idx = sbq.size();
    for (int j = 0; j < sbq.size(); j++) begin
      if (sbq[j].due > due) begin
        idx = j;
        break;
      end
    end
    sbq.insert(idx, it);
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0][15:0] pre, input logic [3:0][15:0] mot);
    @(negedge clk);
    set = s;
    rpmSenseSet = pre;
    motSet = mot;
  endtask

  initial begin
    forever begin
      @(negedge clk or immEv);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        checkOutput(sbq.pop_front());
      end
    end
  end

  initial begin
    int k;
    int m;
    int pv[4];
    int s3[22];
    pv = '{100, 200, -300, 0};
    s3 = '{100, 175, 231, 273, 304, 328, 346, 359, 369, 376, 382,
           386, 389, 391, 393, 394, 395, 396, 397, 398, 399, 400};

    // Reset visible before any clock edge
    #1;
    for (int c = 0; c < 4; c++) expectAt(cyc, 0, c, 0, "reset_rpm");
    expectAt(cyc, 1, 0, 0, "reset_settled");
    ->immEv;
    @(negedge clk);
    resetn = 1'b0;

    // Preload holds while set is high
    applyStimulus(1'b1, pack4(100, 200, -300, 0), pack4(0, 0, 0, 0));
    k = cyc;
    for (int n = 1; n <= 11; n++)
      for (int c = 0; c < 4; c++) expectAt(k + n, 0, c, pv[c], "preload");
    expectAt(k + 1, 1, 0, 0, "preload_settled");
    expectAt(k + 11, 1, 0, 0, "preload_settled_hold");
    expectAt(k + 11, 3, 0, 0, "preload_settled_p4");
    repeat (11) @(negedge clk);

    // Step response, exact convergence, settle, disturbance
    applyStimulus(1'b1, pack4(0, 0, 0, 0), pack4(400, 0, 0, 0));
    applyStimulus(1'b0, pack4(0, 0, 0, 0), pack4(400, 0, 0, 0));
    k = cyc;
    for (int n = 1; n <= 22; n++) expectAt(k + n, 0, 0, s3[n-1], "step_ch0");
    for (int n = 23; n <= 30; n++) expectAt(k + n, 0, 0, 400, "step_hold");
    expectAt(k + 22, 0, 1, 0, "step_ch1_idle");
    expectAt(k + 22, 0, 3, 0, "step_ch3_idle");
    expectAt(k + 25, 1, 0, 0, "settle_early");
    expectAt(k + 26, 1, 0, 1, "settle_on");
    expectAt(k + 30, 1, 0, 1, "settle_stay");
    expectAt(k + 3, 2, 0, 0, "p4_before_tick");
    expectAt(k + 4, 2, 0, 100, "p4_tick1");
    expectAt(k + 7, 2, 0, 100, "p4_hold");
    expectAt(k + 8, 2, 0, 175, "p4_tick2");
    repeat (30) @(negedge clk);
    motSet = pack4(400, 0, 50, 0);
    expectAt(k + 31, 1, 0, 0, "settle_drop");
    expectAt(k + 31, 0, 2, 12, "disturb_ch2");
    expectAt(k + 31, 0, 0, 400, "disturb_ch0");
    repeat (2) @(negedge clk);

    // Slew limit on large error
    applyStimulus(1'b1, pack4(0, 0, 0, 0), pack4(20000, -20000, 0, 0));
    applyStimulus(1'b0, pack4(0, 0, 0, 0), pack4(20000, -20000, 0, 0));
    k = cyc;
    for (int n = 1; n <= 15; n++) begin
      expectAt(k + n, 0, 0, 1000 * n, "slew_pos");
      expectAt(k + n, 0, 1, -1000 * n, "slew_neg");
    end
    expectAt(k + 16, 0, 0, 16000, "slew_t16");
    expectAt(k + 18, 0, 0, 17750, "slew_t18");
    expectAt(k + 4, 2, 0, 1000, "slew_p4");
    repeat (18) @(negedge clk);

    // Full-scale error, then approach to positive rail
    applyStimulus(1'b1, pack4(32767, 0, 0, 0), pack4(-32768, 0, 0, 0));
    applyStimulus(1'b0, pack4(32767, 0, 0, 0), pack4(-32768, 0, 0, 0));
    k = cyc;
    expectAt(k + 1, 0, 0, 31767, "fullscale_t1");
    expectAt(k + 2, 0, 0, 30767, "fullscale_t2");
    expectAt(k + 3, 0, 0, 29767, "fullscale_t3");
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, pack4(32760, 0, 0, 0), pack4(32767, 0, 0, 0));
    applyStimulus(1'b0, pack4(32760, 0, 0, 0), pack4(32767, 0, 0, 0));
    k = cyc;
    for (int n = 1; n <= 7; n++) expectAt(k + n, 0, 0, 32760 + n, "rail_approach");
    for (int n = 8; n <= 10; n++) expectAt(k + n, 0, 0, 32767, "rail_hold");
    repeat (10) @(negedge clk);

    // Async reset mid-ramp, then first tick after release
    applyStimulus(1'b1, pack4(0, 0, 0, 0), pack4(20000, -20000, 0, 0));
    applyStimulus(1'b0, pack4(0, 0, 0, 0), pack4(20000, -20000, 0, 0));
    k = cyc;
    expectAt(k + 3, 0, 0, 3000, "ramp_before_rst");
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    #1;
    expectAt(cyc, 0, 0, 0, "rst_mid_ch0");
    expectAt(cyc, 0, 1, 0, "rst_mid_ch1");
    expectAt(cyc, 1, 0, 0, "rst_mid_settled");
    expectAt(cyc + 1, 0, 0, 0, "rst_hold");
    ->immEv;
    @(negedge clk);
    resetn = 1'b0;
    m = cyc;
    expectAt(m + 1, 0, 0, 1000, "rel_first_tick");
    expectAt(m + 1, 0, 1, -1000, "rel_first_tick_neg");
    expectAt(m + 3, 2, 0, 0, "rel_p4_wait");
    expectAt(m + 4, 2, 0, 1000, "rel_p4_tick");
    repeat (5) @(negedge clk);

    for (int t = 0; t < 100 && sbq.size() > 0; t++) @(negedge clk);
    if (sbq.size() > 0) begin
      $display("[TB] FAIL drain: %0d expectations never checked", sbq.size());
      checks += sbq.size();
      failures += sbq.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
